polygon_draw: RTL and testbench

Parametrised polygon/polyline rasteriser: draws a chain of up to NVERT_MAX vertices from an internal vertex table as connected Bresenham segments, one pixel per enabled clock. Optionally closes the polygon by joining the last vertex back to the first. It sits between the vertex-selection logic and the vga_adapter pixel-write port. It replaces the fixed four-point INIT/DRAW/IDLE sequencer wrapped around draw_line, and emits x/y/drawing directly for the framebuffer write.

---
 rtl/polygon_draw.sv | 267 ++++++++++++++++++++++++++
 tb/tb_polygon_draw.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/polygon_draw.sv
// polygon_draw -- polygon/polyline rasteriser.
//
// Walks a chain of up to NVERT_MAX vertices held in an internal table and
// draws each consecutive pair as an endpoint-inclusive Bresenham segment,
// one pixel per clock while oe is high. With `closed` set, the last vertex
// is joined back to the first. Drives the framebuffer write port directly.
//
// Optional feature macro: POLY_CLIP_EN
//   When defined, drawing is suppressed for pixels outside the
//   XRES x YRES window. The rasteriser still steps through those pixels,
//   so the cycle timing matches the unclipped build.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   vwr_en           vertex-table write strobe (honoured only when idle)
//   vwr_addr         vertex index to write
//   vwr_x, vwr_y     signed vertex coordinates
//   nvert            vertex count, sampled at start (clamped to NVERT_MAX)
//   closed           add the closing segment v[n-1] -> v0, sampled at start
//   start            begin drawing (level, effective only when idle)
//   oe               output enable; low stalls the rasteriser
//   x, y             current signed pixel coordinate
//   drawing          x/y is a valid pixel this cycle
//   busy             request in progress
//   done             one-cycle completion pulse
module polygon_draw #(
  parameter int CORDW     = 12,
  parameter int NVERT_MAX = 8,
  parameter int XRES      = 640,
  parameter int YRES      = 480
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vwr_en,
  input  logic [$clog2(NVERT_MAX)-1:0]   vwr_addr,
  input  logic signed [CORDW-1:0]        vwr_x,
  input  logic signed [CORDW-1:0]        vwr_y,
  input  logic [$clog2(NVERT_MAX):0]     nvert,
  input  logic                           closed,
  input  logic                           start,
  input  logic                           oe,
  output logic signed [CORDW-1:0]        x,
  output logic signed [CORDW-1:0]        y,
  output logic                           drawing,
  output logic                           busy,
  output logic                           done
);

  localparam int AW = $clog2(NVERT_MAX);
  localparam int NW = AW + 1;
  // Two guard bits keep |dx|+|dy| and 2*err in range for any coordinate pair.
  localparam int W  = CORDW + 2;

  localparam logic signed [W-1:0] XRES_W = W'(XRES);
  localparam logic signed [W-1:0] YRES_W = W'(YRES);

`ifdef POLY_CLIP_EN
  localparam logic CLIP_ON = 1'b1;
`else
  localparam logic CLIP_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_DRAW = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                  state_r;
  logic signed [CORDW-1:0] tab_x_r [NVERT_MAX];
  logic signed [CORDW-1:0] tab_y_r [NVERT_MAX];
  logic [NW-1:0]           n_r;
  logic [AW-1:0]           seg_r;
  logic [AW-1:0]           seg_last_r;
  logic signed [CORDW-1:0] p0_x_r, p0_y_r, p1_x_r, p1_y_r;
  logic signed [CORDW-1:0] x_r, y_r;
  logic signed [W-1:0]     dx_r, dy_r, err_r;
  logic                    sx_neg_r, sy_neg_r;
  logic                    busy_r, done_r;

  logic [NW-1:0]           n_s;
  logic [AW-1:0]           seg_last_s;
  logic [NW-1:0]           seg_inc_s;
  logic [AW-1:0]           p1_idx_s;
  logic signed [W-1:0]     diff_x_s, diff_y_s, dx_abs_s, dy_neg_s;
  logic signed [W-1:0]     e2_s, err_step_s;
  logic                    step_x_s, step_y_s, at_end_s, in_window_s;

  // Clamp the requested vertex count and work out the index of the last segment.
  // A single vertex is drawn as one zero-length segment v0 -> v0.
  always_comb begin
    if (nvert > NW'(NVERT_MAX)) begin
      n_s = NW'(NVERT_MAX);
    end else begin
      n_s = nvert;
    end
    if (n_s <= NW'(1)) begin
      seg_last_s = '0;
    end else if (closed) begin
      seg_last_s = AW'(n_s - NW'(1));
    end else begin
      seg_last_s = AW'(n_s - NW'(2));
    end
  end

  // End vertex of the current segment wraps to v0 after the last table entry in use.
  always_comb begin
    seg_inc_s = {1'b0, seg_r} + NW'(1);
    if (seg_inc_s == n_r) begin
      p1_idx_s = '0;
    end else begin
      p1_idx_s = seg_inc_s[AW-1:0];
    end
  end

  // Segment set-up terms, evaluated on the latched endpoints.
  always_comb begin
    diff_x_s = W'(p1_x_r) - W'(p0_x_r);
    diff_y_s = W'(p1_y_r) - W'(p0_y_r);
    if (diff_x_s[W-1]) begin
      dx_abs_s = -diff_x_s;
    end else begin
      dx_abs_s = diff_x_s;
    end
    if (diff_y_s[W-1]) begin
      dy_neg_s = diff_y_s;
    end else begin
      dy_neg_s = -diff_y_s;
    end
  end

  // Bresenham step decision; x and y may both advance in one cycle.
  always_comb begin
    e2_s       = err_r <<< 1;
    step_x_s   = (e2_s >= dy_r);
    step_y_s   = (e2_s <= dx_r);
    err_step_s = err_r;
    if (step_x_s) begin
      err_step_s = err_step_s + dy_r;
    end else begin
      err_step_s = err_step_s;
    end
    if (step_y_s) begin
      err_step_s = err_step_s + dx_r;
    end else begin
      err_step_s = err_step_s;
    end
    at_end_s    = (x_r == p1_x_r) && (y_r == p1_y_r);
    in_window_s = ~x_r[CORDW-1] & ~y_r[CORDW-1] &
                  (W'(x_r) < XRES_W) & (W'(y_r) < YRES_W);
  end

  // Vertex table: writable only while idle, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NVERT_MAX; i++) begin
        tab_x_r[i] <= '0;
        tab_y_r[i] <= '0;
      end
    end else if ((state_r == ST_IDLE) && vwr_en) begin
      tab_x_r[vwr_addr] <= vwr_x;
      tab_y_r[vwr_addr] <= vwr_y;
    end
  end

  // Sequencer and rasteriser datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      n_r        <= '0;
      seg_r      <= '0;
      seg_last_r <= '0;
      p0_x_r     <= '0;
      p0_y_r     <= '0;
      p1_x_r     <= '0;
      p1_y_r     <= '0;
      x_r        <= '0;
      y_r        <= '0;
      dx_r       <= '0;
      dy_r       <= '0;
      err_r      <= '0;
      sx_neg_r   <= 1'b0;
      sy_neg_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            n_r        <= n_s;
            seg_r      <= '0;
            seg_last_r <= seg_last_s;
            if (n_s == '0) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          p0_x_r  <= tab_x_r[seg_r];
          p0_y_r  <= tab_y_r[seg_r];
          p1_x_r  <= tab_x_r[p1_idx_s];
          p1_y_r  <= tab_y_r[p1_idx_s];
          state_r <= ST_INIT;
        end
        ST_INIT: begin
          dx_r     <= dx_abs_s;
          dy_r     <= dy_neg_s;
          err_r    <= dx_abs_s + dy_neg_s;
          // A zero delta steps positively; it never advances that axis anyway.
          sx_neg_r <= diff_x_s[W-1];
          sy_neg_r <= diff_y_s[W-1];
          x_r      <= p0_x_r;
          y_r      <= p0_y_r;
          state_r  <= ST_INIT == ST_INIT ? ST_DRAW : ST_DRAW;
        end
        ST_DRAW: begin
          if (oe) begin
            if (at_end_s) begin
              if (seg_r == seg_last_r) begin
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                seg_r   <= seg_r + AW'(1);
                state_r <= ST_LOAD;
              end
            end else begin
              if (step_x_s) begin
                x_r <= sx_neg_r ? (x_r - CORDW'(1)) : (x_r + CORDW'(1));
              end
              if (step_y_s) begin
                y_r <= sy_neg_r ? (y_r - CORDW'(1)) : (y_r + CORDW'(1));
              end
              err_r <= err_step_s;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign x       = x_r;
  assign y       = y_r;
  // Combinational in oe so a stalled cycle never writes the framebuffer.
  assign drawing = (state_r == ST_DRAW) & oe & (in_window_s | ~CLIP_ON);
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_polygon_draw.sv
// Self-checking bench for polygon_draw: table of draw requests, a
// scoreboard of expected pixels built from a reference Bresenham model,
// and per-request timing/boundary checks.
module tb_polygon_draw;

  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vwr_en = 1'b0;
  logic [2:0] vwr_addr = 3'd0;
  logic signed [11:0] vwr_x = 12'sd0;
  logic signed [11:0] vwr_y = 12'sd0;
  logic [3:0] nvert = 4'd0;
  logic closed = 1'b0;
  logic start = 1'b0;
  logic oe = 1'b1;
  logic signed [11:0] x, y;
  logic drawing, busy, done;

  polygon_draw #(.CORDW(12), .NVERT_MAX(NV), .XRES(640), .YRES(480)) dut (
    .clk(clk), .rst(rst), .vwr_en(vwr_en), .vwr_addr(vwr_addr),
    .vwr_x(vwr_x), .vwr_y(vwr_y), .nvert(nvert), .closed(closed),
    .start(start), .oe(oe), .x(x), .y(y), .drawing(drawing),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nv; bit cl; bit ld;
    int vx[4]; int vy[4];
    int oe_mode; bit disturb; int rst_at;
    int exp_pix; int exp_lx; int exp_ly; int exp_done; int exp_gaps;
  } case_t;

  typedef struct { int x; int y; } pix_t;

  case_t cases[$];
  pix_t  sb[$];
  int    tab_x[NV];
  int    tab_y[NV];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic add_case(input int nv, input bit cl, input bit ld,
                          input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int x3, input int y3,
                          input int oe_mode, input bit disturb, input int rst_at,
                          input int exp_pix, input int exp_lx, input int exp_ly,
                          input int exp_done, input int exp_gaps);
    case_t c;
    c.nv = nv; c.cl = cl; c.ld = ld;
    c.vx[0] = x0; c.vy[0] = y0; c.vx[1] = x1; c.vy[1] = y1;
    c.vx[2] = x2; c.vy[2] = y2; c.vx[3] = x3; c.vy[3] = y3;
    c.oe_mode = oe_mode; c.disturb = disturb; c.rst_at = rst_at;
    c.exp_pix = exp_pix; c.exp_lx = exp_lx; c.exp_ly = exp_ly;
    c.exp_done = exp_done; c.exp_gaps = exp_gaps;
    cases.push_back(c);
  endtask

  task automatic push_pix(input int px, input int py);
    pix_t p;
    p.x = px; p.y = py;
`ifdef POLY_CLIP_EN
    if (px >= 0 && px < 640 && py >= 0 && py < 480) sb.push_back(p);
`else
    sb.push_back(p);
`endif
  endtask

  // Reference line walk (classic integer Bresenham, endpoint inclusive).
  task automatic model_seg(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, cx, cy;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy; cx = x0; cy = y0;
    for (int guard = 0; guard < 5000; guard++) begin
      push_pix(cx, cy);
      if (cx == x1 && cy == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  task automatic build_model(input int nv, input bit cl);
    int n, s_cnt;
    n = (nv > NV) ? NV : nv;
    if (n == 1) model_seg(tab_x[0], tab_y[0], tab_x[0], tab_y[0]);
    else if (n >= 2) begin
      s_cnt = cl ? n : n - 1;
      for (int s = 0; s < s_cnt; s++)
        model_seg(tab_x[s], tab_y[s], tab_x[(s + 1) % n], tab_y[(s + 1) % n]);
    end
  endtask

  task automatic run_case(input int ci);
    case_t c;
    pix_t p;
    int k, npix, last_k, done_k, gaps, lx, ly;
    bit fin;
    c = cases[ci];
    if (c.ld) begin
      for (int i = 0; i < c.nv; i++) begin
        @(posedge clk); #1;
        vwr_en = 1'b1; vwr_addr = 3'(i);
        vwr_x = 12'(c.vx[i]); vwr_y = 12'(c.vy[i]);
        tab_x[i] = c.vx[i]; tab_y[i] = c.vy[i];
      end
      @(posedge clk); #1;
      vwr_en = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b1; nvert = 4'(c.nv); closed = c.cl; oe = 1'b1;
    @(posedge clk); #1;                      // edge T has sampled start
    start = 1'b0; k = 1;
    sb.delete();
    build_model(c.nv, c.cl);
    oe = (c.oe_mode == 1) ? 1'(k % 2) : 1'b1;
    npix = 0; last_k = 0; done_k = 0; gaps = 0; lx = 0; ly = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (k == 1) chk($sformatf("c%0d busy_T+1", ci), int'(busy), (c.nv > 0) ? 1 : 0);
      if (drawing) begin
        npix++;
        if (last_k > 0 && k - last_k == 3) gaps++;
        if (c.oe_mode == 0 && npix == 1) chk($sformatf("c%0d first_pix_cycle", ci), k, 3);
        last_k = k; lx = int'(x); ly = int'(y);
        if (sb.size() == 0) chk($sformatf("c%0d extra_pixel", ci), npix, 0);
        else begin
          p = sb.pop_front();
          chk($sformatf("c%0d pix%0d_x", ci, npix), int'(x), p.x);
          chk($sformatf("c%0d pix%0d_y", ci, npix), int'(y), p.y);
        end
      end
      if (c.oe_mode == 1 && !oe) chk($sformatf("c%0d stall_k%0d", ci, k), int'(drawing), 0);
      if (c.rst_at == k) begin
        chk($sformatf("c%0d pre_rst_drawing", ci), int'(drawing), 1);
        rst = 1'b1; #1;
        chk($sformatf("c%0d rst_busy", ci), int'(busy), 0);
        chk($sformatf("c%0d rst_drawing", ci), int'(drawing), 0);
        chk($sformatf("c%0d rst_done", ci), int'(done), 0);
        chk($sformatf("c%0d rst_x", ci), int'(x), 0);
        chk($sformatf("c%0d rst_y", ci), int'(y), 0);
        for (int i = 0; i < NV; i++) begin tab_x[i] = 0; tab_y[i] = 0; end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        fin = 1'b1;
      end else if (done) begin
        done_k = k;
        chk($sformatf("c%0d busy_at_done", ci), int'(busy), 0);
        fin = 1'b1;
      end else if (k >= 400) begin
        chk($sformatf("c%0d timeout", ci), k, 0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        k++;
        oe = (c.oe_mode == 1) ? 1'(k % 2) : 1'b1;
        if (c.disturb && k == 5) begin
          start = 1'b1; nvert = 4'd0; vwr_en = 1'b1; vwr_addr = 3'd0;
          vwr_x = 12'sd100; vwr_y = 12'sd100;
        end
        if (c.disturb && k == 6) begin
          start = 1'b0; vwr_en = 1'b0;
        end
      end
    end
    if (c.rst_at == 0) begin
      chk($sformatf("c%0d done_cycle", ci), done_k, c.exp_done);
      chk($sformatf("c%0d pix_count", ci), npix, c.exp_pix);
      chk($sformatf("c%0d sb_left", ci), sb.size(), 0);
      if (c.exp_pix > 0) begin
        chk($sformatf("c%0d last_x", ci), lx, c.exp_lx);
        chk($sformatf("c%0d last_y", ci), ly, c.exp_ly);
        chk($sformatf("c%0d done_after_last", ci), done_k, last_k + 1);
      end
      if (c.exp_gaps >= 0) chk($sformatf("c%0d seg_gaps", ci), gaps, c.exp_gaps);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("c%0d done_pulse_len", ci), int'(done), 0);
      chk($sformatf("c%0d idle_busy", ci), int'(busy), 0);
    end
    oe = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin tab_x[i] = 0; tab_y[i] = 0; end
    //        nv cl ld  x0 y0 x1 y1 x2 y2 x3 y3 oe dis rst  pix lx ly done gaps
    add_case(4, 1, 1,  0, 0, 3, 0, 3, 3, 0, 3, 0, 0, 0,  16, 0, 0, 25, 3);  // closed square
    add_case(4, 0, 1,  0, 0, 3, 0, 3, 3, 0, 3, 0, 0, 0,  12, 0, 3, 19, 2);  // open polyline
    add_case(2, 0, 1,  0, 0, 5, 2, 0, 0, 0, 0, 0, 0, 0,   6, 5, 2,  9, 0);  // diagonal
    add_case(2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   6, 5, 2, 14, -1); // diagonal, oe toggling
    add_case(2, 0, 1,  0, 0, 5, 2, 0, 0, 0, 0, 0, 1, 0,   6, 5, 2,  9, 0);  // start/vwr_en mid-draw
    add_case(2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   6, 5, 2,  9, 0);  // table must be unchanged
    add_case(1, 0, 1,  7, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 7, 9,  4, 0);  // single point
    add_case(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  1, 0);  // empty request
`ifdef POLY_CLIP_EN
    add_case(2, 0, 1, -2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0,   3, 2, 0,  8, 0);  // left-edge clip
`else
    add_case(2, 0, 1, -2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0,   5, 2, 0,  8, 0);  // off-screen passes through
`endif
    add_case(4, 1, 1,  0, 0, 3, 0, 3, 3, 0, 3, 0, 0, 5,   0, 0, 0,  0, 0);  // reset mid-segment
    add_case(4, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 13, 3);  // cleared table, seg 0 restart

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_drawing", int'(drawing), 0);
    chk("reset_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int ci = 0; ci < cases.size(); ci++) run_case(ci);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
